// File: rtl/riscat_pkg.sv
// rtl/riscat_pkg.sv - shared types and widths for the register-file sequencer
package riscat_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } seq_state_t;

  function automatic logic idx_in_range(input logic [REG_IDX_W-1:0] idx, input int n);
    return int'(idx) < n;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - register index to one-hot-or-zero enable vector
module onehot_decoder
  import riscat_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [N-1:0]         vec
);

  // Indices at or beyond N match no bit, so the vector stays all-zero.
  always_comb begin
    vec = '0;
    for (int i = 0; i < N; i++) begin
      vec[i] = en && (int'(idx) == i);
    end
  end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - read/execute/writeback sequencer driving the register file enables
module regfile_sequencer
  import riscat_pkg::*;
#(
  parameter int NREGS       = 32,
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 use_rs2,
  input  logic                 wb_en,
  input  logic [XLEN-1:0]      alu_result,
  output logic [NREGS-1:0]     out0_en,
  output logic [NREGS-1:0]     out1_en,
  output logic [NREGS-1:0]     load,
  output logic [XLEN-1:0]      wr_data,
  output logic                 retire,
  output logic                 idx_err
);

  seq_state_t           state;
  logic [REG_IDX_W-1:0] rs1_q;
  logic [REG_IDX_W-1:0] rs2_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic                 use_rs2_q;
  logic                 wb_en_q;
  logic [CNT_W-1:0]     cnt;
  logic [XLEN-1:0]      hold;

  logic in_read;
  logic in_write;
  logic last_read;
  logic rs1_bad;
  logic rs2_bad;
  logic rd_bad;
  logic do_write;
  logic finish_read;
  logic accept;

  // Every output is gated by reset so nothing reaches the cells while it is sampled high.
  assign in_read     = !reset && (state == READ);
  assign in_write    = !reset && (state == WRITE);
  assign last_read   = in_read && (cnt == CNT_W'(EXEC_CYCLES - 1));
  assign rs1_bad     = !idx_in_range(rs1_q, NREGS);
  assign rs2_bad     = !idx_in_range(rs2_q, NREGS);
  assign rd_bad      = !idx_in_range(rd_q, NREGS);
  assign do_write    = wb_en_q && (rd_q != '0) && !rd_bad;
  assign finish_read = last_read && !do_write;

  assign instr_ready = !reset && ((state == IDLE) || in_write || finish_read);
  assign retire      = in_write || finish_read;
  assign idx_err     = in_read && (cnt == '0) &&
                       (rs1_bad || (use_rs2_q && rs2_bad) || (wb_en_q && rd_bad));
  assign wr_data     = reset ? '0 : hold;
  assign accept      = instr_valid && instr_ready;

  onehot_decoder #(.N(NREGS)) u_dec_a (
    .idx (rs1_q),
    .en  (in_read),
    .vec (out0_en)
  );

  onehot_decoder #(.N(NREGS)) u_dec_b (
    .idx (rs2_q),
    .en  (in_read && use_rs2_q),
    .vec (out1_en)
  );

  onehot_decoder #(.N(NREGS)) u_dec_ld (
    .idx (rd_q),
    .en  (in_write),
    .vec (load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs2_q <= 1'b0;
      wb_en_q   <= 1'b0;
    end else begin
      if (last_read) begin
        hold <= alu_result;
      end
      if (accept) begin
        rs1_q     <= rs1;
        rs2_q     <= rs2;
        rd_q      <= rd;
        use_rs2_q <= use_rs2;
        wb_en_q   <= wb_en;
        cnt       <= '0;
        state     <= READ;
      end else begin
        case (state)
          IDLE:  state <= IDLE;
          READ: begin
            if (last_read) begin
              state <= do_write ? WRITE : IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WRITE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  a_out0_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(out0_en));
  a_out1_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(out1_en));
  a_load_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(load));
  a_load_x0:     assert property (@(posedge clk) !load[0]);
  a_no_rw_clash: assert property (@(posedge clk) ((out0_en | out1_en) & load) == '0);
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - randomized and directed checks of two sequencer configurations
module tb_regfile_sequencer;

  localparam int NCFG = 2;
  localparam int NRA [NCFG] = '{32, 16};
  localparam int ECA [NCFG] = '{1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s    [NCFG];
  logic        iv_s     [NCFG];
  logic [4:0]  rs1_s    [NCFG];
  logic [4:0]  rs2_s    [NCFG];
  logic [4:0]  rd_s     [NCFG];
  logic        use2_s   [NCFG];
  logic        wb_s     [NCFG];
  logic [31:0] salt_s   [NCFG];
  logic        salt_rand[NCFG];

  logic        ready_o  [NCFG];
  logic        retire_o [NCFG];
  logic        err_o    [NCFG];
  logic [31:0] o0_o     [NCFG];
  logic [31:0] o1_o     [NCFG];
  logic [31:0] ld_o     [NCFG];
  logic [31:0] wd_o     [NCFG];
  logic [31:0] bus_a_o  [NCFG];

  logic [31:0] rf  [NCFG][32];
  logic [31:0] mrf [NCFG][32];

  bit          m_busy [NCFG];
  int          m_age  [NCFG];
  int          m_rs1  [NCFG];
  int          m_rs2  [NCFG];
  int          m_rd   [NCFG];
  bit          m_use2 [NCFG];
  bit          m_wb   [NCFG];
  logic [31:0] m_held [NCFG];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int NR = NRA[g];
    logic [NR-1:0] o0, o1, ld;
    logic [31:0]   ba, bb, alu;

    regfile_sequencer #(.NREGS(NR), .XLEN(32), .EXEC_CYCLES(ECA[g])) dut (
      .clk         (clk),
      .reset       (rst_s[g]),
      .instr_valid (iv_s[g]),
      .instr_ready (ready_o[g]),
      .rs1         (rs1_s[g]),
      .rs2         (rs2_s[g]),
      .rd          (rd_s[g]),
      .use_rs2     (use2_s[g]),
      .wb_en       (wb_s[g]),
      .alu_result  (alu),
      .out0_en     (o0),
      .out1_en     (o1),
      .load        (ld),
      .wr_data     (wd_o[g]),
      .retire      (retire_o[g]),
      .idx_err     (err_o[g])
    );

    // Tri-state buses: enabled registers drive, an undriven bus reads as zero.
    always_comb begin
      ba = '0;
      bb = '0;
      for (int i = 0; i < NR; i++) begin
        if (o0[i]) ba = ba | rf[g][i];
        if (o1[i]) bb = bb | rf[g][i];
      end
    end

    assign alu        = ba + bb + salt_s[g];
    assign o0_o[g]    = 32'(o0);
    assign o1_o[g]    = 32'(o1);
    assign ld_o[g]    = 32'(ld);
    assign bus_a_o[g] = ba;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] opnd(input int c, input int idx);
    return (idx < NRA[c]) ? mrf[c][idx] : 32'd0;
  endfunction

  // Transaction-level model: each op is "age" cycles past its accept edge.
  task automatic model_cycle(input int c);
    int nr, ec;
    bit bad, wr;
    logic [31:0] e_o0, e_o1, e_ld, e_wd;
    logic e_rdy, e_ret, e_err;
    nr = NRA[c];
    ec = ECA[c];
    e_o0 = '0; e_o1 = '0; e_ld = '0; e_wd = '0;
    e_rdy = 1'b0; e_ret = 1'b0; e_err = 1'b0;
    bad = (m_rs1[c] >= nr) || (m_use2[c] && m_rs2[c] >= nr) || (m_wb[c] && m_rd[c] >= nr);
    wr  = m_wb[c] && (m_rd[c] != 0) && (m_rd[c] < nr);
    if (!rst_s[c]) begin
      if (!m_busy[c]) begin
        e_rdy = 1'b1;
      end else if (m_age[c] <= ec) begin
        if (m_rs1[c] < nr) e_o0 = 32'd1 << m_rs1[c];
        if (m_use2[c] && m_rs2[c] < nr) e_o1 = 32'd1 << m_rs2[c];
        e_err = (m_age[c] == 1) && bad;
        if (m_age[c] == ec && !wr) begin
          e_ret = 1'b1;
          e_rdy = 1'b1;
        end
      end else begin
        e_ld  = 32'd1 << m_rd[c];
        e_ret = 1'b1;
        e_rdy = 1'b1;
      end
      e_wd = m_held[c];
    end
    chk($sformatf("c%0d out0_en", c), o0_o[c], e_o0);
    chk($sformatf("c%0d out1_en", c), o1_o[c], e_o1);
    chk($sformatf("c%0d load", c), ld_o[c], e_ld);
    chk($sformatf("c%0d wr_data", c), wd_o[c], e_wd);
    chk($sformatf("c%0d instr_ready", c), 32'(ready_o[c]), 32'(e_rdy));
    chk($sformatf("c%0d retire", c), 32'(retire_o[c]), 32'(e_ret));
    chk($sformatf("c%0d idx_err", c), 32'(err_o[c]), 32'(e_err));

    if (rst_s[c]) begin
      m_busy[c] = 1'b0;
      m_held[c] = '0;
      for (int i = 0; i < 32; i++) begin
        mrf[c][i] = '0;
        rf[c][i]  = '0;
      end
    end else begin
      if (m_busy[c] && m_age[c] == ec + 1) mrf[c][m_rd[c]] = m_held[c];
      for (int i = 1; i < 32; i++) begin
        if (ld_o[c][i]) rf[c][i] = wd_o[c];
      end
      if (m_busy[c] && m_age[c] == ec)
        m_held[c] = opnd(c, m_rs1[c]) + (m_use2[c] ? opnd(c, m_rs2[c]) : 32'd0) + salt_s[c];
      if (e_rdy && iv_s[c]) begin
        m_busy[c] = 1'b1;
        m_age[c]  = 1;
        m_rs1[c]  = int'(rs1_s[c]);
        m_rs2[c]  = int'(rs2_s[c]);
        m_rd[c]   = int'(rd_s[c]);
        m_use2[c] = use2_s[c];
        m_wb[c]   = wb_s[c];
      end else if (e_ret) begin
        m_busy[c] = 1'b0;
      end else if (m_busy[c]) begin
        m_age[c]++;
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NCFG; c++) begin
      m_busy[c] = 1'b0; m_age[c] = 0; m_held[c] = '0;
      m_rs1[c] = 0; m_rs2[c] = 0; m_rd[c] = 0; m_use2[c] = 1'b0; m_wb[c] = 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf[c][i]  = '0;
        mrf[c][i] = '0;
      end
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) model_cycle(c);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) begin
      if (salt_rand[c]) salt_s[c] = $urandom;
    end
  endtask

  task automatic offer(input int c, input int a, input int b, input int d, input bit u, input bit w);
    rs1_s[c]  = 5'(a);
    rs2_s[c]  = 5'(b);
    rd_s[c]   = 5'(d);
    use2_s[c] = u;
    wb_s[c]   = w;
    iv_s[c]   = 1'b1;
  endtask

  logic [31:0] sampled;

  initial begin
    for (int c = 0; c < NCFG; c++) begin
      rst_s[c] = 1'b1; iv_s[c] = 1'b0;
      rs1_s[c] = '0; rs2_s[c] = '0; rd_s[c] = '0; use2_s[c] = 1'b0; wb_s[c] = 1'b0;
      salt_rand[c] = 1'b1; salt_s[c] = $urandom;
    end
    repeat (3) step();
    chk("reset instr_ready", 32'(ready_o[0]), 32'd0);
    chk("reset wr_data", wd_o[0], 32'd0);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    #1;
    chk("idle instr_ready", 32'(ready_o[1]), 32'd1);

    // EXEC_CYCLES=1 writeback of a fixed ALU value
    salt_rand[0] = 1'b0;
    salt_s[0] = 32'hDEADBEEF;
    offer(0, 3, 4, 7, 1'b1, 1'b1);
    step();
    iv_s[0] = 1'b0;
    chk("A out0_en", o0_o[0], 32'h0000_0008);
    chk("A out1_en", o1_o[0], 32'h0000_0010);
    chk("A no retire in READ", 32'(retire_o[0]), 32'd0);
    step();
    chk("A load", ld_o[0], 32'h0000_0080);
    chk("A wr_data", wd_o[0], 32'hDEADBEEF);
    chk("A retire", 32'(retire_o[0]), 32'd1);
    step();
    chk("A x7 readback", rf[0][7], 32'hDEADBEEF);

    // rd=0 never loads and retires in the READ cycle
    offer(0, 1, 2, 0, 1'b1, 1'b1);
    step();
    iv_s[0] = 1'b0;
    chk("rd0 retire", 32'(retire_o[0]), 32'd1);
    chk("rd0 load", ld_o[0], 32'd0);
    step();
    chk("rd0 load after", ld_o[0], 32'd0);

    // back-to-back with valid held high; op2 fields presented while not ready
    salt_s[0] = 32'h0000_1234;
    offer(0, 0, 0, 9, 1'b0, 1'b1);
    step();
    offer(0, 9, 0, 10, 1'b0, 1'b1);
    step();
    chk("B2B op1 load", ld_o[0], 32'h0000_0200);
    chk("B2B op1 wr_data", wd_o[0], 32'h0000_1234);
    step();
    iv_s[0] = 1'b0;
    chk("B2B op2 out0_en", o0_o[0], 32'h0000_0200);
    chk("B2B bus A", bus_a_o[0], 32'h0000_1234);
    step();
    chk("B2B op2 wr_data", wd_o[0], 32'h0000_2468);
    chk("B2B op2 load", ld_o[0], 32'h0000_0400);
    step();
    salt_rand[0] = 1'b1;

    // EXEC_CYCLES=3, operand B undriven, ALU input changes every cycle
    offer(1, 2, 6, 5, 1'b0, 1'b1);
    step();
    iv_s[1] = 1'b0;
    chk("E3 c1 out0_en", o0_o[1], 32'h4);
    chk("E3 c1 out1_en", o1_o[1], 32'h0);
    step();
    chk("E3 c2 out0_en", o0_o[1], 32'h4);
    step();
    chk("E3 c3 out0_en", o0_o[1], 32'h4);
    sampled = salt_s[1];
    step();
    chk("E3 wr_data", wd_o[1], sampled);
    chk("E3 load", ld_o[1], 32'h20);
    step();

    // out-of-range rs1 on the 16-register configuration
    offer(1, 20, 0, 3, 1'b0, 1'b0);
    step();
    iv_s[1] = 1'b0;
    chk("OOR out0_en", o0_o[1], 32'd0);
    chk("OOR idx_err", 32'(err_o[1]), 32'd1);
    step();
    chk("OOR idx_err once", 32'(err_o[1]), 32'd0);
    step();
    chk("OOR retire", 32'(retire_o[1]), 32'd1);
    step();

    // reset held two edges in the middle of a READ
    offer(1, 1, 0, 5, 1'b0, 1'b1);
    step();
    iv_s[1] = 1'b0;
    rst_s[1] = 1'b1;
    #1;
    chk("RST ready", 32'(ready_o[1]), 32'd0);
    chk("RST out0_en", o0_o[1], 32'd0);
    step();
    step();
    rst_s[1] = 1'b0;
    #1;
    chk("RST release ready", 32'(ready_o[1]), 32'd1);
    chk("RST release retire", 32'(retire_o[1]), 32'd0);
    step();

    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < NCFG; c++) begin
        rst_s[c]  = ($urandom_range(0, 299) == 0);
        iv_s[c]   = ($urandom_range(0, 3) != 0);
        rs1_s[c]  = 5'($urandom);
        rs2_s[c]  = 5'($urandom);
        rd_s[c]   = 5'($urandom);
        use2_s[c] = 1'($urandom);
        wb_s[c]   = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    for (int c = 0; c < NCFG; c++) begin
      rst_s[c] = 1'b0;
      iv_s[c]  = 1'b0;
    end
    repeat (8) step();
    for (int c = 0; c < NCFG; c++) begin
      for (int i = 0; i < NRA[c]; i++) begin
        chk($sformatf("c%0d x%0d readback", c, i), rf[c][i], mrf[c][i]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Control stage directly upstream of the 32-bit register file built from register32bit cells.
- Accepts one decoded register-register operation per handshake.
- Drives the per-register out0_en/out1_en tri-state enables onto operand buses A/B, holds them for the ALU, captures the result, then pulses the destination load with the held result on the write bus.
- Runs on posedge clk, so all enables and write data are stable across the register cells' negedge capture.

Parameters:
- NREGS, 32: number of architectural registers; index 0 is hard-zero and never loaded.
- XLEN, 32: data width of the write bus and the result holding register.
- EXEC_CYCLES, 1: cycles the operand enables are held before the ALU result is sampled (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  operation offered.
- instr_ready  output  1  sequencer can accept this cycle.
- rs1  input  5  operand A register index.
- rs2  input  5  operand B register index.
- rd  input  5  destination register index.
- use_rs2  input  1  drive bus B from rs2; 0 leaves bus B undriven.
- wb_en  input  1  write the result back.
- alu_result  input  XLEN  combinational ALU output, derived from buses A/B.
- out0_en  output  NREGS  one-hot-or-zero enable vector for bus A.
- out1_en  output  NREGS  one-hot-or-zero enable vector for bus B.
- load  output  NREGS  one-hot-or-zero load vector; bit 0 always 0.
- wr_data  output  XLEN  write bus value; the held result.
- retire  output  1  one-cycle pulse when an operation completes.
- idx_err  output  1  one-cycle pulse when an accepted index is >= NREGS.

Behaviour:
- Clocking and reset: one clock clk; reset is synchronous and active-high. The top level ties the register cells' reset_n to ~reset.
- While reset is sampled high:
  - state goes to IDLE and the cycle counter clears;
  - out0_en, out1_en, load, retire and idx_err are 0;
  - wr_data is 0;
  - instr_ready is 0.
- Reset mid-operation abandons the operation: no load pulse and no retire. After reset is released, the first cycle is IDLE.
- States (enum seq_state_t): IDLE, READ, WRITE.
- IDLE:
  - instr_ready = 1 and all enables are 0.
  - On instr_valid, latch rs1/rs2/rd/use_rs2/wb_en, clear the counter, and go to READ.
- READ, held for exactly EXEC_CYCLES cycles:
  - out0_en[rs1] = 1; out1_en[rs2] = use_rs2.
  - In the last READ cycle (counter == EXEC_CYCLES-1), sample alu_result into the holding register.
  - If wb_en and rd != 0 and rd < NREGS, go to WRITE.
  - Otherwise pulse retire in this same cycle. instr_ready = 1 in this cycle, and the sequencer goes to READ if instr_valid is high, else to IDLE.
- WRITE, one cycle:
  - load[rd] = 1; wr_data = held value; retire = 1; instr_ready = 1.
  - On instr_valid, latch the new operation and go to READ, else go to IDLE.
  - Back-to-back operations are hazard-free: the register captures on the negedge inside WRITE, before the next READ cycle begins.
- Latency: from the accept edge, retire occurs EXEC_CYCLES cycles later with no writeback, or EXEC_CYCLES+1 cycles later with writeback.
- Throughput: one operation every EXEC_CYCLES(+1) cycles.
- wr_data holds its value outside WRITE and changes only at the sample point.
- Index out of range (rs1, rs2 with use_rs2, or rd with wb_en >= NREGS):
  - the corresponding enable bit is not driven;
  - idx_err pulses in the first READ cycle;
  - the operation otherwise completes, with the write suppressed.
- rs1 == rs2: both vectors have the same bit set. This is legal because they drive separate buses.
- instr_valid while not ready is ignored; the inputs are not latched.
- Assertions (simulation only):
  - $onehot0 holds on each of out0_en, out1_en and load;
  - load[0] is never 1;
  - no load and out-enable to the same register in the same cycle.

Decomposition:
- riscat_pkg holds:
  - seq_state_t;
  - REG_IDX_W = 5;
  - XLEN_DEFAULT = 32;
  - the EXEC_CYCLES counter width (4).
- One sub-module, onehot_decoder (params N; inputs idx[REG_IDX_W], en; output vec[N], all-zero when idx >= N or !en). It is instantiated three times, for out0_en, out1_en and load.

Test Plan:
- Reset sampled high for 2 cycles mid-READ of an op (rd=5) -> all outputs 0, no load[5] pulse, no retire; IDLE with instr_ready=1 on the first cycle after release.
- EXEC_CYCLES=1; rs1=3, rs2=4, rd=7, wb_en=1, alu_result=32'hDEADBEEF -> next cycle out0_en=1<<3 and out1_en=1<<4; following cycle load=1<<7, wr_data=32'hDEADBEEF, retire=1; register x7 reads back DEADBEEF.
- rd=0, wb_en=1 -> load stays 0 throughout; retire in the last READ cycle; latency EXEC_CYCLES.
- Two ops back-to-back (op1 writes x9=32'h1234, op2 reads rs1=9) with instr_valid held high -> op2 READ immediately follows op1 WRITE; bus A carries 32'h1234; no idle cycle.
- EXEC_CYCLES=3, use_rs2=0 -> out0_en held for exactly 3 cycles, out1_en=0; alu_result sampled only in the 3rd cycle (value changed between cycles 1–3 must not leak).
- NREGS=16, rs1=20 -> out0_en=0, idx_err pulses once, retire still occurs; no assertion fires.
